whack_score_keeper: RTL
=======================

WHACK_SCORE_KEEPER -- requirements
Module: whack_score_keeper

Interface
REQ-001 Parameter N_HOLES, default 5: number of mole holes and whack keys.
REQ-002 Parameter SCORE_W, default 8: score counter width.
REQ-003 Parameter MAX_MISS, default 3: miss count that ends the game (must be 1 or more).
REQ-004 Parameter LED_CYC, default 16: hit-LED stretch length in clk cycles (must be 1 or more).
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 Port key_esc, input, 1 bit: synchronous game restart, active-high.
REQ-008 Port key_space, input, 1 bit: pause key; a rising edge toggles pause.
REQ-009 Port mole_new, input, 1 bit: one-cycle pulse; a mole appears at mole_sel.
REQ-010 Port mole_sel, input, N_HOLES bits: one-hot hole index; sampled only when mole_new=1.
REQ-011 Port mole_expire, input, 1 bit: one-cycle pulse; the current mole's time is up.
REQ-012 Port keys, input, N_HOLES bits: level key inputs, already debounced and synchronous to clk.
REQ-013 Port score, output, SCORE_W bits: count of correct whacks.
REQ-014 Port misses, output, $clog2(MAX_MISS+1) bits: count of misses.
REQ-015 Port game_lose, output, 1 bit: high while in LOST.
REQ-016 Port paused, output, 1 bit: high while in PAUSED.
REQ-017 Port hit_pulse, output, 1 bit: one-cycle registered pulse per counted hit.
REQ-018 Port led, output, 1 bit: hit feedback, stretched to LED_CYC cycles.

Function
REQ-019 FSM states: PLAY, PAUSED, LOST.
- PLAY to PAUSED: key_space rising edge.
- PAUSED to PLAY: key_space rising edge.
- PLAY to LOST: misses reaches MAX_MISS.
- LOST is left only through key_esc or rst_n.
REQ-020 Edge detection uses registered previous values of keys and key_space; only 0-to-1 transitions count; a held key counts once.
REQ-021 mole_new in PLAY or PAUSED loads mole_sel into an internal one-hot register and sets armed=1; the updated value is visible from the next cycle.
REQ-022 In PLAY, a key edge is judged against the registered mole state from before that cycle's mole_new.
REQ-023 Hit: in PLAY, armed=1 and a key edge on the armed hole.
- Effects: score+1 (saturates at all-ones), hit_pulse=1 next cycle, armed cleared, LED counter loaded with LED_CYC.
- At most one hit per mole.
REQ-024 Wrong whack: in PLAY, key edges with no hit (wrong hole, or armed=0) add exactly one miss per cycle, regardless of how many keys rose.
REQ-025 If a hit and wrong-hole edges occur in the same cycle, the hit wins and no miss is counted.
REQ-026 Escape: mole_expire in PLAY with armed=1 and no hit that cycle adds one miss and clears armed.
- mole_expire with armed=0 has no effect.
REQ-027 A wrong whack and an escape in the same cycle add one miss in total, not two.
REQ-028 If a hit and mole_expire occur in the same cycle, the hit counts and no miss is counted.
REQ-029 misses saturates at MAX_MISS.
- The cycle it reaches MAX_MISS, the FSM enters LOST; game_lose=1 the following cycle.
REQ-030 In PAUSED and LOST: score, misses and armed hold (mole_new may still reload them in PAUSED), key edges are discarded, mole_expire is ignored, and the LED counter keeps counting down.
REQ-031 While in LOST, key_space edges are ignored.
REQ-032 led = (LED counter != 0); the counter decrements by 1 per cycle down to 0; a new hit reloads it to LED_CYC.
REQ-033 key_esc has highest synchronous priority; in the same cycle it forces:
- state PLAY; score, misses, armed, LED counter and hit_pulse to 0;
- edge registers loaded with the current inputs, so a held key does not count.
REQ-034 All outputs are registered; there is no combinational path from input to output.

Reset
REQ-035 While rst_n=0, all state is forced asynchronously:
- state PLAY; score=0, misses=0, game_lose=0, paused=0, hit_pulse=0, led=0;
- armed=0; mole register, LED counter and edge registers all 0.
REQ-036 Reset deassertion takes effect at the first clk rising edge after rst_n goes high.
REQ-037 Asserting reset in the middle of a game discards all progress; there is no retained state.

Structure
REQ-038 A shared package whack_pkg holds the FSM state enum (PLAY, PAUSED, LOST) and the default constants N_HOLES_DEF=5 and MAX_MISS_DEF=3.
REQ-039 One sub-module, edge_rise: a parametrised-width rising-edge detector with clk, rst_n and a sync clear input, instantiated once for keys and once for key_space.

Verification
REQ-040 Hit: reset; mole_new with mole_sel=00100; keys[2] rises 3 cycles later.
- score=1, hit_pulse high for exactly 1 cycle, led high for 16 cycles, misses=0.
- Holding keys[2] for 10 further cycles keeps score=1.
REQ-041 Wrong whack: mole at 00001; keys[3] and keys[4] rise in the same cycle.
- misses=1, score=0, armed still set; a following keys[0] edge gives score=1.
REQ-042 Loss: three escapes via mole_expire.
- misses=3 and game_lose=1 on the cycle after the third.
- Further mole_new, keys and key_space inputs change nothing; key_esc returns all outputs to 0.
REQ-043 Pause: key_space edge, then a mole with a correct key edge; score stays 0 and paused=1.
- A second key_space edge gives paused=0; a new key edge on the armed hole gives score=1.
REQ-044 Saturation and simultaneity, with SCORE_W=2:
- 5 hits give score=3.
- A hit and mole_expire in the same cycle give a hit counted, misses unchanged.
- rst_n low mid-LED asynchronously gives led=0 and score=0.

Source files
------------

// File: rtl/whack_pkg.sv
// Shared types and default constants for the whack-a-mole score keeper.
package whack_pkg;

    // Game FSM states.
    typedef enum logic [1:0] {
        PLAY   = 2'd0,
        PAUSED = 2'd1,
        LOST   = 2'd2
    } state_e;

    localparam int N_HOLES_DEF  = 5;
    localparam int MAX_MISS_DEF = 3;

    // True when any bit of a hole vector is set.
    function automatic logic any_hole(input logic [31:0] vec);
        return (vec != 32'd0);
    endfunction

endpackage

// File: rtl/edge_rise.sv
// Parametrised-width rising-edge detector. The previous-value register always
// tracks the input, so a synchronous clear simply masks the output for one
// cycle while re-arming the detector on the current levels.
module edge_rise #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] rise
);

    logic [W-1:0] prev_q;
    logic [W-1:0] prev_d;

    // Next value of the previous-sample register and the edge output.
    always_comb begin
        prev_d = d;
        if (clr) begin
            rise = {W{1'b0}};
        end else begin
            rise = d & ~prev_q;
        end
    end

    // Previous-sample register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= {W{1'b0}};
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/whack_score_keeper.sv
// Whack-a-mole score keeper: tracks the armed mole, judges key edges as hits
// or misses, counts score and misses, and runs a PLAY/PAUSED/LOST FSM.
// All outputs come straight from flops.
module whack_score_keeper
    import whack_pkg::*;
#(
    parameter int N_HOLES  = N_HOLES_DEF,
    parameter int SCORE_W  = 8,
    parameter int MAX_MISS = MAX_MISS_DEF,
    parameter int LED_CYC  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          key_esc,
    input  logic                          key_space,
    input  logic                          mole_new,
    input  logic [N_HOLES-1:0]            mole_sel,
    input  logic                          mole_expire,
    input  logic [N_HOLES-1:0]            keys,
    output logic [SCORE_W-1:0]            score,
    output logic [$clog2(MAX_MISS+1)-1:0] misses,
    output logic                          game_lose,
    output logic                          paused,
    output logic                          hit_pulse,
    output logic                          led
);

    localparam int MW = $clog2(MAX_MISS + 1);
    localparam int LW = $clog2(LED_CYC + 1);

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [MW-1:0]      misses_q, misses_d;
    logic               armed_q, armed_d;
    logic [N_HOLES-1:0] mole_q, mole_d;
    logic [LW-1:0]      led_cnt_q, led_cnt_d;
    logic               hit_pulse_q, hit_pulse_d;
    logic               game_lose_q, game_lose_d;
    logic               paused_q, paused_d;
    logic               led_q, led_d;

    logic [N_HOLES-1:0] key_rise_s;
    logic [0:0]         space_rise_s;
    logic               play_s;
    logic               hit_s;
    logic               wrong_s;
    logic               escape_s;
    logic               miss_s;

    edge_rise #(.W(N_HOLES)) u_key_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (key_esc),
        .d     (keys),
        .rise  (key_rise_s)
    );

    edge_rise #(.W(1)) u_space_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (key_esc),
        .d     (key_space),
        .rise  (space_rise_s)
    );

    // Judge this cycle's key edges and expiry against the mole registered before it.
    always_comb begin
        play_s   = (state_q == PLAY);
        hit_s    = play_s && armed_q && any_hole(32'(key_rise_s & mole_q));
        wrong_s  = play_s && any_hole(32'(key_rise_s)) && !hit_s;
        escape_s = play_s && mole_expire && armed_q && !hit_s;
        miss_s   = wrong_s || escape_s;
    end

    // Next-state, counter and output logic for the game FSM.
    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        misses_d    = misses_q;
        armed_d     = armed_q;
        mole_d      = mole_q;
        hit_pulse_d = 1'b0;
        if (led_cnt_q != {LW{1'b0}}) begin
            led_cnt_d = led_cnt_q - LW'(1);
        end else begin
            led_cnt_d = led_cnt_q;
        end

        if (key_esc) begin
            state_d   = PLAY;
            score_d   = {SCORE_W{1'b0}};
            misses_d  = {MW{1'b0}};
            armed_d   = 1'b0;
            mole_d    = {N_HOLES{1'b0}};
            led_cnt_d = {LW{1'b0}};
        end else begin
            case (state_q)
                PLAY: begin
                    if (hit_s) begin
                        if (&score_q) begin
                            score_d = score_q;
                        end else begin
                            score_d = score_q + SCORE_W'(1);
                        end
                        hit_pulse_d = 1'b1;
                        led_cnt_d   = LW'(LED_CYC);
                        armed_d     = 1'b0;
                    end else begin
                        score_d = score_q;
                    end
                    if (miss_s) begin
                        if (misses_q == MW'(MAX_MISS)) begin
                            misses_d = misses_q;
                        end else begin
                            misses_d = misses_q + MW'(1);
                        end
                    end else begin
                        misses_d = misses_q;
                    end
                    if (escape_s) begin
                        armed_d = 1'b0;
                    end else begin
                        armed_d = armed_d;
                    end
                    // A fresh mole overrides any clear from this cycle's hit or escape.
                    if (mole_new) begin
                        mole_d  = mole_sel;
                        armed_d = 1'b1;
                    end else begin
                        mole_d = mole_q;
                    end
                    if (misses_d == MW'(MAX_MISS)) begin
                        state_d = LOST;
                    end else if (space_rise_s[0]) begin
                        state_d = PAUSED;
                    end else begin
                        state_d = PLAY;
                    end
                end
                PAUSED: begin
                    if (mole_new) begin
                        mole_d  = mole_sel;
                        armed_d = 1'b1;
                    end else begin
                        mole_d = mole_q;
                    end
                    if (space_rise_s[0]) begin
                        state_d = PLAY;
                    end else begin
                        state_d = PAUSED;
                    end
                end
                LOST: begin
                    state_d = LOST;
                end
                default: begin
                    state_d = PLAY;
                end
            endcase
        end

        game_lose_d = (state_d == LOST);
        paused_d    = (state_d == PAUSED);
        led_d       = (led_cnt_d != {LW{1'b0}});
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PLAY;
            score_q     <= {SCORE_W{1'b0}};
            misses_q    <= {MW{1'b0}};
            armed_q     <= 1'b0;
            mole_q      <= {N_HOLES{1'b0}};
            led_cnt_q   <= {LW{1'b0}};
            hit_pulse_q <= 1'b0;
            game_lose_q <= 1'b0;
            paused_q    <= 1'b0;
            led_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            misses_q    <= misses_d;
            armed_q     <= armed_d;
            mole_q      <= mole_d;
            led_cnt_q   <= led_cnt_d;
            hit_pulse_q <= hit_pulse_d;
            game_lose_q <= game_lose_d;
            paused_q    <= paused_d;
            led_q       <= led_d;
        end
    end

    assign score     = score_q;
    assign misses    = misses_q;
    assign game_lose = game_lose_q;
    assign paused    = paused_q;
    assign hit_pulse = hit_pulse_q;
    assign led       = led_q;

endmodule
